// File: rtl/mvm_host_if.sv
// Stream bundle between the host and its producer/consumer.
// s_* carries frame words in, r_* carries result words out.
interface mvm_host_if #(
    parameter int B = 16
);
    logic [B-1:0]   s_data;
    logic           s_valid;
    logic           s_ready;
    logic [2*B-1:0] r_data;
    logic           r_valid;
    logic           r_ready;

    modport master (
        output s_data, s_valid, r_ready,
        input  s_ready, r_data, r_valid
    );

    modport slave (
        input  s_data, s_valid, r_ready,
        output s_ready, r_data, r_valid
    );
endinterface

// File: rtl/mvm_host.sv
// Host sequencer: buffers a matrix/vector frame, feeds the MVM, drains results.
// Optional MVM_HOST_MATRIX_REUSE_EN adds keep_matrix for vector-only frames.
module mvm_host #(
    parameter int K        = 12,
    parameter int B        = 16,
    parameter int DONE_LAT = 2
) (
    input  logic           clk,
    input  logic           reset,
    mvm_host_if.slave      hs,
`ifdef MVM_HOST_MATRIX_REUSE_EN
    input  logic           keep_matrix,
`endif
    output logic           loadMatrix,
    output logic           loadVector,
    output logic           start,
    output logic [B-1:0]   mvm_data,
    input  logic           done,
    input  logic [2*B-1:0] mvm_result,
    output logic           busy
);
    localparam int NW = K*K + K;
    localparam int CW = $clog2(NW + DONE_LAT + 2);
    localparam int AW = $clog2(NW);
    localparam int RW = (K > 1) ? $clog2(K) : 1;

    localparam logic [CW-1:0] C_1   = CW'(1);
    localparam logic [CW-1:0] C_MM  = CW'(K*K);
    localparam logic [CW-1:0] C_K   = CW'(K);
    localparam logic [CW-1:0] C_K1  = CW'(K-1);
    localparam logic [CW-1:0] C_NW1 = CW'(NW-1);
    localparam logic [CW-1:0] C_DL  = CW'(DONE_LAT);

    typedef enum logic [2:0] {
        FILL, SEND_M, SEND_V, START, WAIT, COLLECT, DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [B-1:0]    buf_q [NW];
    logic [2*B-1:0]  res_q [K];
    logic            wr_en, cap, v_only;
    logic [AW-1:0]   widx;
    logic [RW-1:0]   cidx;
    logic [CW-1:0]   f_last;
    logic            s_rdy, r_vld;
    logic [2*B-1:0]  r_dat;

`ifdef MVM_HOST_MATRIX_REUSE_EN
    logic keep_q, have_m;

    // The reuse decision is latched with the first word of each frame
    assign v_only = (cnt_q == '0) ? (keep_matrix & have_m) : keep_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            keep_q <= 1'b0;
            have_m <= 1'b0;
        end else begin
            if (wr_en && cnt_q == '0)
                keep_q <= keep_matrix & have_m;
            if (state_q == SEND_M)
                have_m <= 1'b1;
        end
    end
`else
    assign v_only = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            buf_q[widx] <= hs.s_data;
        if (cap)
            res_q[cidx] <= mvm_result;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_en      = 1'b0;
        cap        = 1'b0;
        cidx       = '0;
        loadMatrix = 1'b0;
        loadVector = 1'b0;
        start      = 1'b0;
        mvm_data   = '0;
        s_rdy      = 1'b0;
        r_vld      = 1'b0;
        r_dat      = '0;
        f_last     = v_only ? C_K1 : C_NW1;
        widx       = v_only ? AW'(cnt_q + C_MM) : AW'(cnt_q);
        unique case (state_q)
            FILL: begin
                s_rdy = ~reset;
                if (hs.s_valid && s_rdy) begin
                    wr_en = 1'b1;
                    if (cnt_q == f_last) begin
                        cnt_d   = '0;
                        state_d = v_only ? SEND_V : SEND_M;
                    end else begin
                        cnt_d = cnt_q + C_1;
                    end
                end
            end
            SEND_M: begin
                if (cnt_q == '0)
                    loadMatrix = 1'b1;
                else
                    mvm_data = buf_q[AW'(cnt_q - C_1)];
                if (cnt_q == C_MM) begin
                    cnt_d   = '0;
                    state_d = SEND_V;
                end else begin
                    cnt_d = cnt_q + C_1;
                end
            end
            SEND_V: begin
                if (cnt_q == '0)
                    loadVector = 1'b1;
                else
                    mvm_data = buf_q[AW'(cnt_q + C_MM - C_1)];
                if (cnt_q == C_K) begin
                    cnt_d   = '0;
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + C_1;
                end
            end
            START: begin
                start   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (done) begin
                    state_d = COLLECT;
                    cnt_d   = C_1;
                    if (DONE_LAT == 0) cap = 1'b1;
                end
            end
            COLLECT: begin
                // cnt_q counts cycles since the done pulse
                cnt_d = cnt_q + C_1;
                if (cnt_q >= C_DL) begin
                    cap  = 1'b1;
                    cidx = RW'(cnt_q - C_DL);
                    if (cnt_q - C_DL == C_K1) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                r_vld = 1'b1;
                r_dat = res_q[RW'(cnt_q)];
                if (hs.r_ready) begin
                    if (cnt_q == C_K1) begin
                        cnt_d   = '0;
                        state_d = FILL;
                    end else begin
                        cnt_d = cnt_q + C_1;
                    end
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase
    end

    assign hs.s_ready = s_rdy;
    assign hs.r_valid = r_vld;
    assign hs.r_data  = r_dat;
    assign busy       = (state_q != FILL);
endmodule
